// File: rtl/i2c_txn_arbiter_pkg.sv
// Shared definitions for the I2C transaction arbiter: FSM encoding,
// default parameters and bus field widths.
package i2c_arb_pkg;

    localparam int N_REQ_DEF       = 4;
    localparam int TIMEOUT_CYC_DEF = 65535;
    localparam int ADDR_W          = 7;
    localparam int DATA_W          = 8;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE,
        RESP
    } arb_state_e;

endpackage

// File: rtl/i2c_txn_arbiter_if.sv
// Requester handshake and I2C-master command/status bundle.
// The arbiter sits on the slave modport, requesters and the I2C master on master.
interface i2c_txn_arbiter_if
    import i2c_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF
) ();

    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_rw;
    logic [ADDR_W*N_REQ-1:0] req_addr;
    logic [DATA_W*N_REQ-1:0] req_wdata;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]       rsp_rdata;
    logic                    rsp_err;

    logic                    m_start;
    logic                    m_rw;
    logic [ADDR_W-1:0]       m_addr;
    logic [DATA_W-1:0]       m_wdata;
    logic                    m_busy;
    logic                    m_done;
    logic [DATA_W-1:0]       m_rd_data;

    modport slave (
        input  req_valid, req_rw, req_addr, req_wdata, m_busy, m_done, m_rd_data,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, m_start, m_rw, m_addr, m_wdata
    );

    modport master (
        output req_valid, req_rw, req_addr, req_wdata, m_busy, m_done, m_rd_data,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, m_start, m_rw, m_addr, m_wdata
    );

endinterface

// File: rtl/i2c_txn_arbiter_rr_arbiter.sv
// Combinational round-robin grant: first set request found starting at ptr_i,
// wrapping modulo N_REQ; one-hot (or zero) grant.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [PW-1:0]    ptr_i,
    output logic [N_REQ-1:0] grant_o
);

    logic          found;
    logic [PW-1:0] idx;

    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        idx     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = PW'((int'(ptr_i) + i) % N_REQ);
            if (!found && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_txn_arbiter.sv
// Serialises N_REQ requesters onto a single I2C master, one transaction at a time,
// with round-robin fairness and a per-transaction timeout.
module i2c_txn_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int N_REQ       = N_REQ_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic              clk,
    input  logic              rst,
    i2c_txn_arbiter_if.slave  bus
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    arb_state_e        state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [CW-1:0]     tcnt_q, tcnt_d;
    logic [N_REQ-1:0]  owner_q, owner_d;
    logic [N_REQ-1:0]  ready_q, ready_d;
    logic              rw_q, rw_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic busy_meta_q, busy_sync_q;
    logic done_meta_q, done_sync_q, done_prev_q;
    logic done_rise, tmo;

    logic [N_REQ-1:0]  grant;
    logic              sel_rw;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [PW-1:0]     sel_next_ptr;

    rr_arbiter #(.N_REQ(N_REQ), .PW(PW)) u_rr (
        .req_i   (bus.req_valid),
        .ptr_i   (ptr_q),
        .grant_o (grant)
    );

    always_comb begin
        sel_rw       = 1'b0;
        sel_addr     = '0;
        sel_wdata    = '0;
        sel_next_ptr = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                sel_rw       = bus.req_rw[i];
                sel_addr     = bus.req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata    = bus.req_wdata[i*DATA_W +: DATA_W];
                sel_next_ptr = (i == N_REQ - 1) ? '0 : PW'(i + 1);
            end
        end
    end

    // m_busy/m_done come from another clock domain; only the synchronised copies are used.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_meta_q <= 1'b0;
            busy_sync_q <= 1'b0;
            done_meta_q <= 1'b0;
            done_sync_q <= 1'b0;
            done_prev_q <= 1'b0;
        end else begin
            busy_meta_q <= bus.m_busy;
            busy_sync_q <= busy_meta_q;
            done_meta_q <= bus.m_done;
            done_sync_q <= done_meta_q;
            done_prev_q <= done_sync_q;
        end
    end

    assign done_rise = done_sync_q & ~done_prev_q;
    assign tmo       = (tcnt_q == CW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            tcnt_q  <= '0;
            owner_q <= '0;
            ready_q <= '0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            tcnt_q  <= tcnt_d;
            owner_q <= owner_d;
            ready_q <= ready_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        tcnt_d  = tcnt_q;
        owner_d = owner_q;
        ready_d = '0;
        rw_d    = rw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (|grant) begin
                    state_d = LAUNCH;
                    ready_d = grant;
                    owner_d = grant;
                    rw_d    = sel_rw;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    ptr_d   = sel_next_ptr;
                    tcnt_d  = '0;
                    rdata_d = '0;
                    err_d   = 1'b0;
                end
            end
            LAUNCH, WAIT_BUSY: begin
                tcnt_d = tcnt_q + 1'b1;
                if (tmo) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else if (busy_sync_q) begin
                    state_d = WAIT_DONE;
                end else begin
                    state_d = WAIT_BUSY;
                end
            end
            WAIT_DONE: begin
                tcnt_d = tcnt_q + 1'b1;
                // A completion arriving on the last allowed cycle still counts as success.
                if (done_rise) begin
                    state_d = RESP;
                    err_d   = 1'b0;
                    rdata_d = rw_q ? bus.m_rd_data : '0;
                end else if (tmo) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.req_ready = ready_q;
    assign bus.rsp_valid = (state_q == RESP) ? owner_q : '0;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
    assign bus.m_start   = (state_q == LAUNCH) || (state_q == WAIT_BUSY);
    assign bus.m_rw      = rw_q;
    assign bus.m_addr    = addr_q;
    assign bus.m_wdata   = wdata_q;

endmodule

// File: doc/i2c_txn_arbiter.md
I2C_TXN_ARBITER -- requirements
Module: i2c_txn_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters, range 2..8.
REQ-002 Parameter TIMEOUT_CYC, default 65535: clk cycles allowed per transaction before abort.
REQ-003 clk  input  1  system clock; the only clock, all logic on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  N_REQ  per-requester transaction request, held until accepted.
REQ-006 req_rw  input  N_REQ  per-requester direction; 0=write, 1=read.
REQ-007 req_addr  input  7*N_REQ  per-requester 7-bit slave address; requester i uses slice [7i+6:7i].
REQ-008 req_wdata  input  8*N_REQ  per-requester write byte; requester i uses slice [8i+7:8i].
REQ-009 req_ready  output  N_REQ  one-hot, one-cycle accept pulse.
REQ-010 rsp_valid  output  N_REQ  one-hot, one-cycle completion pulse to the owning requester.
REQ-011 rsp_rdata  output  8  read byte, valid with rsp_valid.
REQ-012 rsp_err  output  1  timeout flag, valid with rsp_valid.
REQ-013 m_start, m_rw  output  1 each; m_addr  output  7; m_wdata  output  8  command to the I2C master.
REQ-014 m_busy, m_done  input  1 each; m_rd_data  input  8  status and data from the I2C master, asynchronous to clk.

Function
REQ-015 The block SHALL pass m_busy and m_done through 2-flop synchronizers before using them; m_rd_data SHALL be sampled only on the cycle the synchronized done rises.
REQ-016 The FSM SHALL have states IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, RESP.
REQ-017 IDLE: if any req_valid is set, grant by round-robin from ptr. Assert req_ready[g] for one cycle and latch rw/addr/wdata of g. Go to LAUNCH.
REQ-018 Round-robin: search order ptr, ptr+1, ... modulo N_REQ. After a grant, ptr = g+1 modulo N_REQ.
REQ-019 LAUNCH/WAIT_BUSY: hold m_start=1 and keep the latched command stable. When synchronized busy is 1, go to WAIT_DONE and drop m_start.
REQ-020 WAIT_DONE: on the rising edge of synchronized done, capture m_rd_data (forced to 0 for writes) and go to RESP.
REQ-021 RESP: pulse rsp_valid[g] for one cycle with rsp_rdata and rsp_err, then go to IDLE; no grant is made in the RESP cycle.
REQ-022 Timeout: a counter clears on grant and counts in LAUNCH/WAIT_BUSY/WAIT_DONE. At TIMEOUT_CYC it SHALL go to RESP with rsp_err=1 and rsp_rdata=0, and drop m_start.
REQ-023 At most one transaction is outstanding. req_valid changes on non-granted requesters while busy SHALL have no effect.
REQ-024 If req_valid[g] is deasserted after grant, the transaction SHALL still complete and respond.
REQ-025 m_addr, m_rw and m_wdata SHALL be constant from grant until RESP.

Reset
REQ-026 On rst: state=IDLE, ptr=0, timeout counter=0, synchronizers=0.
REQ-027 On rst: req_ready, rsp_valid, rsp_rdata, rsp_err, m_start, m_rw, m_addr and m_wdata SHALL all be 0.
REQ-028 Reset mid-transaction SHALL abandon the transaction silently, with no rsp_valid pulse.

Structure
REQ-029 Package i2c_arb_pkg SHALL hold the FSM state encoding, the N_REQ and TIMEOUT_CYC defaults, and the address width (7) and data width (8).
REQ-030 Grant selection SHALL be a sub-module rr_arbiter (request vector plus ptr in, one-hot grant out, purely combinational); the FSM, counters and synchronizers stay in the top module.

Verification
REQ-031 Single write: requester 2 sends addr=0x50, wdata=0xA5 -> m_addr=0x50, m_rw=0, m_wdata=0xA5; rsp_valid[2] with rsp_err=0.
REQ-032 Read: requester 0 reads addr=0x3C while the slave returns 0x5A -> rsp_rdata=0x5A on rsp_valid[0].
REQ-033 Fairness: all four requesters held valid from reset -> grant order 0,1,2,3,0, each served exactly once per round.
REQ-034 Timeout: TIMEOUT_CYC=100, m_busy tied 0 -> rsp_valid with rsp_err=1 exactly 100 cycles after grant; m_start low afterwards.
REQ-035 Reset in WAIT_DONE -> all outputs 0 next cycle, no rsp_valid; a subsequent request is granted to the lowest-index valid requester (ptr=0).
REQ-036 req_valid[1] dropped the cycle after grant -> the transaction still completes and rsp_valid[1] pulses.
